// File: rtl/lagd_reg_bcast_demux_if.sv
// Register bus bundle for the broadcast demux: the upstream request/response
// group (s_*) and the shared downstream target group (m_*).
interface lagd_reg_bcast_demux_if #(
  parameter int unsigned NumTargets = 4,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 32
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  // Upstream side
  logic                                 s_valid_i;
  logic                                 s_write_i;
  logic [AddrWidth-1:0]                 s_addr_i;
  logic [DataWidth-1:0]                 s_wdata_i;
  logic [StrbWidth-1:0]                 s_wstrb_i;
  logic [DataWidth-1:0]                 s_rdata_o;
  logic                                 s_error_o;
  logic                                 s_ready_o;

  // Downstream side, request fields shared by every target
  logic [NumTargets-1:0]                m_valid_o;
  logic                                 m_write_o;
  logic [AddrWidth-1:0]                 m_addr_o;
  logic [DataWidth-1:0]                 m_wdata_o;
  logic [StrbWidth-1:0]                 m_wstrb_o;
  logic [NumTargets-1:0][DataWidth-1:0] m_rdata_i;
  logic [NumTargets-1:0]                m_error_i;
  logic [NumTargets-1:0]                m_ready_i;

  // Requester view: issues requests, receives the one-cycle response
  modport master (
    output s_valid_i, s_write_i, s_addr_i, s_wdata_i, s_wstrb_i,
    input  s_rdata_o, s_error_o, s_ready_o
  );

  // Demux view: serves the requester and fans out to the targets
  modport slave (
    input  s_valid_i, s_write_i, s_addr_i, s_wdata_i, s_wstrb_i,
    output s_rdata_o, s_error_o, s_ready_o,
    output m_valid_o, m_write_o, m_addr_o, m_wdata_o, m_wstrb_o,
    input  m_rdata_i, m_error_i, m_ready_i
  );

  // Target-array view
  modport target (
    input  m_valid_o, m_write_o, m_addr_o, m_wdata_o, m_wstrb_o,
    output m_rdata_i, m_error_i, m_ready_i
  );
endinterface

// File: rtl/lagd_reg_bcast_demux.sv
// Register-bus demultiplexer: routes one upstream request to a single Ising
// core target (unicast) or to all targets at once (broadcast write), collects
// the completions and returns a single registered response strobe.
module lagd_reg_bcast_demux #(
  parameter int unsigned NumTargets    = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdxLsb        = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  lagd_reg_bcast_demux_if.slave bus,
  output logic [NumTargets-1:0] to_sticky_o,
  input  logic                  clr_i
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  // Index field is wide enough to hold NumTargets, so all-ones is never a valid target
  localparam int unsigned IdxW = ($clog2(NumTargets + 1) > 1) ? $clog2(NumTargets + 1) : 1;
  localparam int unsigned CntW = ($clog2(TimeoutCycles + 1) > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [IdxW-1:0] IdxNum  = IdxW'(NumTargets);
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam bit              TimeoutEn = (TimeoutCycles != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UNI   = 2'd1,
    BCAST = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic [NumTargets-1:0] pending_q, pending_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumTargets-1:0] sticky_q, sticky_d;

  logic [IdxW-1:0]                      req_idx;
  logic [NumTargets-1:0]                req_onehot;
  logic [NumTargets-1:0]                ready_hit;
  logic [NumTargets-1:0]                pending_left;
  logic [NumTargets-1:0][DataWidth-1:0] rdata_masked;
  logic [DataWidth-1:0]                 rdata_sel;
  logic                                 err_hit;
  logic                                 timeout;
  logic                                 resp_active;

  assign req_idx = bus.s_addr_i[IdxLsb +: IdxW];

  // A ready only counts for a target that is currently being driven valid
  assign ready_hit    = pending_q & bus.m_ready_i;
  assign pending_left = pending_q & ~bus.m_ready_i;
  assign err_hit      = |(ready_hit & bus.m_error_i);
  assign timeout      = TimeoutEn && (cnt_q == CntLast);

  // Per-target index decode and read-data masking
  for (genvar gi = 0; gi < NumTargets; gi++) begin : g_target
    assign req_onehot[gi]   = (req_idx == IdxW'(gi));
    assign rdata_masked[gi] = ready_hit[gi] ? bus.m_rdata_i[gi] : '0;
  end

  // OR-combine the masked read data; in unicast at most one lane is live
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NumTargets; i++) begin
      rdata_sel = rdata_sel | rdata_masked[i];
    end
  end

  // Next-state and datapath updates for the request/response sequencer
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    // Clear first so that a timeout set in the same cycle overrides it
    sticky_d  = clr_i ? '0 : sticky_q;

    unique case (state_q)
      IDLE: begin
        if (bus.s_valid_i) begin
          write_d = bus.s_write_i;
          addr_d  = bus.s_addr_i;
          wdata_d = bus.s_wdata_i;
          wstrb_d = bus.s_wstrb_i;
          cnt_d   = '0;
          rdata_d = '0;
          error_d = 1'b0;
          if (req_idx < IdxNum) begin
            pending_d = req_onehot;
            state_d   = UNI;
          end else if ((req_idx == '1) && bus.s_write_i) begin
            pending_d = '1;
            state_d   = BCAST;
          end else begin
            // Unmapped index or broadcast read: answer with an error directly
            error_d = 1'b1;
            state_d = RESP;
          end
        end
      end

      UNI: begin
        cnt_d = cnt_q + CntW'(1);
        if (pending_left == '0) begin
          rdata_d   = rdata_sel;
          error_d   = err_hit;
          pending_d = '0;
          state_d   = RESP;
        end else if (timeout) begin
          sticky_d  = sticky_d | pending_left;
          rdata_d   = '0;
          error_d   = 1'b1;
          pending_d = '0;
          state_d   = RESP;
        end
      end

      BCAST: begin
        cnt_d     = cnt_q + CntW'(1);
        pending_d = pending_left;
        error_d   = error_q | err_hit;
        rdata_d   = '0;
        if (pending_left == '0) begin
          state_d = RESP;
        end else if (timeout) begin
          // Targets that answered this very cycle are not flagged
          sticky_d  = sticky_d | pending_left;
          error_d   = 1'b1;
          pending_d = '0;
          state_d   = RESP;
        end
      end

      RESP: begin
        rdata_d = '0;
        error_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and request registers, cleared asynchronously so a reset aborts at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      pending_q <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      cnt_q     <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      pending_q <= pending_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
    end
  end

  // The pending mask doubles as the per-target valid in both unicast and broadcast
  assign bus.m_valid_o = pending_q;
  assign bus.m_write_o = write_q;
  assign bus.m_addr_o  = addr_q;
  assign bus.m_wdata_o = wdata_q;
  assign bus.m_wstrb_o = wstrb_q;

  // Response fields read as zero outside the response strobe
  assign resp_active   = (state_q == RESP);
  assign bus.s_ready_o = resp_active;
  assign bus.s_rdata_o = resp_active ? rdata_q : '0;
  assign bus.s_error_o = resp_active & error_q;

  assign to_sticky_o = sticky_q;

endmodule

// File: tb/tb_lagd_reg_bcast_demux.sv
// Directed bench for lagd_reg_bcast_demux: stimulus pushes expected responses
// into a queue, a negedge monitor pops and compares whenever s_ready_o is high.
module tb_lagd_reg_bcast_demux;
  localparam int unsigned NT = 4;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          error;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [NT-1:0] sticky;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  exp_t          exp_q[$];

  lagd_reg_bcast_demux_if #(.NumTargets(NT), .AddrWidth(AW), .DataWidth(DW)) bus ();

  lagd_reg_bcast_demux #(
    .NumTargets(NT), .AddrWidth(AW), .DataWidth(DW), .IdxLsb(16), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus),
    .to_sticky_o(sticky),
    .clr_i(clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input logic [2:0] idx);
    logic [AW-1:0] a;
    a = 48'hA000_0000_0040;
    a[18:16] = idx;
    return a;
  endfunction

  task automatic issue(input logic wr, input logic [2:0] idx, input logic [DW-1:0] wd,
                       input logic [3:0] strb);
    bus.s_valid_i = 1'b1;
    bus.s_write_i = wr;
    bus.s_addr_i  = mk_addr(idx);
    bus.s_wdata_i = wd;
    bus.s_wstrb_i = strb;
  endtask

  task automatic expect_resp(input logic [DW-1:0] rd, input logic er, input int lat);
    exp_t e;
    e.rdata = rd;
    e.error = er;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
  endtask

  // Response monitor: compares every strobe against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.s_ready_o) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: cycle %0d got rdata=0x%0h err=%0b required none",
                     cyc, bus.s_rdata_o, bus.s_error_o);
          end else begin
            e = exp_q.pop_front();
            if (bus.s_rdata_o !== e.rdata || bus.s_error_o !== e.error || cyc != e.cyc) begin
              errors++;
              $display("FAIL resp: cycle %0d rdata=0x%0h err=%0b, required cycle %0d rdata=0x%0h err=%0b",
                       cyc, bus.s_rdata_o, bus.s_error_o, e.cyc, e.rdata, e.error);
            end else begin
              $display("resp cycle %0d rdata=0x%0h err=%0b ok", cyc, bus.s_rdata_o, bus.s_error_o);
            end
          end
        end else begin
          checks++;
          if (bus.s_rdata_o !== '0 || bus.s_error_o !== 1'b0) begin
            errors++;
            $display("FAIL resp_idle_zero: cycle %0d got rdata=0x%0h err=%0b required 0",
                     cyc, bus.s_rdata_o, bus.s_error_o);
          end
        end
      end
    end
  end

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_write_i = 1'b0;
    bus.s_addr_i  = '0;
    bus.s_wdata_i = '0;
    bus.s_wstrb_i = '0;
    bus.m_rdata_i = '0;
    bus.m_error_i = '0;
    bus.m_ready_i = '0;

    // Reset state
    repeat (3) step();
    chk("rst_m_valid", bus.m_valid_o, 0);
    chk("rst_s_ready", bus.s_ready_o, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_m_addr", bus.m_addr_o, 0);
    rst_n = 1'b1;
    step();

    // Unicast read to target 2, same-cycle ready
    $display("txn unicast read idx=2");
    issue(1'b0, 3'd2, 32'h0, 4'h0);
    expect_resp(32'hCAFE_0001, 1'b0, 2);
    step();
    bus.s_valid_i = 1'b0;
    chk("uni_valid", bus.m_valid_o, 4'b0100);
    chk("uni_addr", bus.m_addr_o, mk_addr(3'd2));
    chk("uni_write", bus.m_write_o, 0);
    bus.m_ready_i    = 4'b0100;
    bus.m_rdata_i[2] = 32'hCAFE_0001;
    step();
    bus.m_ready_i = '0;
    chk("uni_valid_drop", bus.m_valid_o, 0);
    step();

    // Unicast write to target 1; a ready from unselected target 3 must be ignored
    $display("txn unicast write idx=1 with stray ready");
    issue(1'b1, 3'd1, 32'hDEAD_BEEF, 4'h5);
    expect_resp(32'h1111_0000, 1'b0, 3);
    step();
    bus.s_valid_i = 1'b0;
    chk("uw_valid", bus.m_valid_o, 4'b0010);
    chk("uw_wdata", bus.m_wdata_o, 32'hDEAD_BEEF);
    chk("uw_wstrb", bus.m_wstrb_o, 4'h5);
    bus.m_ready_i    = 4'b1000;
    bus.m_error_i    = 4'b1000;
    bus.m_rdata_i[3] = 32'hFFFF_FFFF;
    step();
    chk("uw_stray_ignored", bus.m_valid_o, 4'b0010);
    bus.m_ready_i    = 4'b0010;
    bus.m_error_i    = 4'b0000;
    bus.m_rdata_i[1] = 32'h1111_0000;
    step();
    bus.m_ready_i = '0;
    chk("uw_valid_drop", bus.m_valid_o, 0);
    step();

    // Broadcast write, readies at cycles 1,3,3,5 with target 1 erroring
    $display("txn broadcast write");
    issue(1'b1, 3'd7, 32'h1234_5678, 4'hF);
    expect_resp(32'h0, 1'b1, 6);
    step();
    bus.s_valid_i = 1'b0;
    chk("bc_valid_c1", bus.m_valid_o, 4'hF);
    bus.m_ready_i = 4'b0001;
    step();
    bus.m_ready_i = '0;
    chk("bc_valid_c2", bus.m_valid_o, 4'hE);
    step();
    chk("bc_valid_c3", bus.m_valid_o, 4'hE);
    bus.m_ready_i = 4'b0110;
    bus.m_error_i = 4'b0010;
    step();
    bus.m_ready_i = '0;
    bus.m_error_i = '0;
    chk("bc_valid_c4", bus.m_valid_o, 4'h8);
    step();
    chk("bc_valid_c5", bus.m_valid_o, 4'h8);
    bus.m_ready_i = 4'b1000;
    step();
    bus.m_ready_i = '0;
    chk("bc_valid_c6", bus.m_valid_o, 0);
    step();

    // Broadcast read and unmapped index: immediate error, no downstream traffic
    $display("txn broadcast read");
    issue(1'b0, 3'd7, 32'h0, 4'h0);
    expect_resp(32'h0, 1'b1, 1);
    step();
    bus.s_valid_i = 1'b0;
    chk("bcrd_no_valid", bus.m_valid_o, 0);
    step();
    $display("txn unmapped write idx=5");
    issue(1'b1, 3'd5, 32'h5555_5555, 4'hF);
    expect_resp(32'h0, 1'b1, 1);
    step();
    bus.s_valid_i = 1'b0;
    chk("unmap_no_valid", bus.m_valid_o, 0);
    step();

    // Unicast timeout on target 0, then sticky clear
    $display("txn unicast timeout idx=0");
    issue(1'b0, 3'd0, 32'h0, 4'h0);
    expect_resp(32'h0, 1'b1, 9);
    step();
    bus.s_valid_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("to_valid_c%0d", k), bus.m_valid_o, 4'b0001);
      step();
    end
    chk("to_valid_drop", bus.m_valid_o, 0);
    chk("to_sticky_set", sticky, 4'b0001);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("to_sticky_clr", sticky, 0);
    step();

    // Broadcast timeout: ready on the timeout cycle wins, set beats clear
    $display("txn broadcast timeout");
    issue(1'b1, 3'd7, 32'hABCD_0000, 4'h3);
    expect_resp(32'h0, 1'b1, 9);
    step();
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 4'b0101;
    step();
    bus.m_ready_i = '0;
    chk("bto_valid_c2", bus.m_valid_o, 4'b1010);
    repeat (6) step();
    chk("bto_valid_c8", bus.m_valid_o, 4'b1010);
    bus.m_ready_i = 4'b1000;
    clr = 1'b1;
    step();
    bus.m_ready_i = '0;
    clr = 1'b0;
    chk("bto_valid_drop", bus.m_valid_o, 0);
    chk("bto_sticky", sticky, 4'b0010);
    step();

    // Reset in the middle of a broadcast with pending = 0x6
    $display("txn broadcast aborted by reset");
    issue(1'b1, 3'd7, 32'h0F0F_0F0F, 4'hF);
    step();
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = 4'b1001;
    step();
    bus.m_ready_i = '0;
    chk("rstmid_pending", bus.m_valid_o, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_valid", bus.m_valid_o, 0);
    chk("rstmid_sticky", sticky, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    $display("txn unicast read idx=3 after reset");
    issue(1'b0, 3'd3, 32'h0, 4'h0);
    expect_resp(32'hA5A5_5A5A, 1'b0, 2);
    step();
    bus.s_valid_i = 1'b0;
    chk("post_rst_valid", bus.m_valid_o, 4'b1000);
    bus.m_ready_i    = 4'b1000;
    bus.m_rdata_i[3] = 32'hA5A5_5A5A;
    step();
    bus.m_ready_i = '0;
    step();

    // Back-to-back with s_valid_i held: second request only after the response
    $display("txn back-to-back");
    bus.m_ready_i    = 4'b0001;
    bus.m_rdata_i[0] = 32'hB0B0_0001;
    issue(1'b0, 3'd0, 32'h0, 4'h0);
    expect_resp(32'hB0B0_0001, 1'b0, 2);
    expect_resp(32'h0, 1'b1, 4);
    step();
    bus.s_write_i = 1'b1;
    bus.s_addr_i  = mk_addr(3'd5);
    chk("b2b_addr_held", bus.m_addr_o, mk_addr(3'd0));
    chk("b2b_valid_c1", bus.m_valid_o, 4'b0001);
    step();
    chk("b2b_valid_c2", bus.m_valid_o, 0);
    step();
    chk("b2b_valid_c3", bus.m_valid_o, 0);
    step();
    bus.s_valid_i = 1'b0;
    bus.m_ready_i = '0;
    chk("b2b_valid_c4", bus.m_valid_o, 0);
    step();

    // Bounded drain of outstanding expectations
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("drain_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
